uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
- UART receiver; the receive-side counterpart to BaudTickGen, which paces the transmitter.
- Consumes an oversampled tick from a BaudTickGen instance configured with Oversampling = OVERSAMPLING and enable tied high.
- Recovers 8N1 (configurable data width) frames from the asynchronous rxd line, LSB first.
- Delivers each byte with a one-cycle valid pulse and flags framing errors.
- Sits between the board RX pin and the byte-consumer logic, in the clk domain.

Parameters:
- OVERSAMPLING, 8, ticks per bit period; power of two, >= 4.
- DATA_BITS, 8, data bits per frame, 5..8.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous active-high reset.
- os_tick  input  1  oversample strobe, one clk wide, OVERSAMPLING per bit period.
- rxd  input  1  raw serial line; asynchronous; idle high.
- data  output  DATA_BITS  last received byte; held until the next good frame.
- data_valid  output  1  one-cycle pulse when data updates.
- framing_err  output  1  one-cycle pulse when a bad stop bit is detected.
- busy  output  1  high while state != IDLE.

Behaviour:
- Reset (async, active-high):
  - state = IDLE; all counters = 0.
  - data = 0; data_valid = 0; framing_err = 0; busy = 0.
  - Synchronizer flops reset to 1.
  - A reset mid-frame abandons the frame with no pulse.
- Synchronizer:
  - rxd passes through 2 flops to give rxd_s; all decisions use rxd_s.
  - rxd_s is 2 clks of latency behind rxd.
- Sampling and counters:
  - All state and counter activity advances only on clk edges where os_tick = 1; other cycles hold.
  - os_cnt is a log2(OVERSAMPLING)-bit counter, cleared on each bit boundary.
  - Samples are taken at os_cnt = M-1, M, M+1, where M = OVERSAMPLING/2.
  - The bit value is the majority of the 3 samples, decided at os_cnt = M+1 (the "decision point").
- IDLE:
  - On a tick with rxd_s = 0, go to START with os_cnt = 0.
- START:
  - At the decision point, a vote of 1 is a false start: go to IDLE, no outputs.
  - Otherwise, at os_cnt = OVERSAMPLING-1, go to DATA with os_cnt = 0 and bit_cnt = 0.
- DATA:
  - At the decision point, shift the vote into shift_reg from the MSB side (shift right), so the first bit received ends up in bit 0.
  - At os_cnt = OVERSAMPLING-1: wrap os_cnt and increment bit_cnt.
  - After DATA_BITS bits, go to STOP.
- STOP, at the decision point:
  - Vote 1: data <= shift_reg, data_valid = 1 for one clk, next state IDLE.
  - Vote 0: framing_err = 1 for one clk, data unchanged, no valid, next state BREAK.
  - Returning to IDLE at mid-stop-bit allows resync on back-to-back frames.
- BREAK:
  - Stay until a tick with rxd_s = 1, then go to IDLE.
  - This prevents a held-low line (break) from retriggering.
- Output timing: data_valid, framing_err and data are registered. They assert the clk after the decision-point tick.
- Simultaneous events: when a tick and reset coincide, reset wins. Back-to-back ticks (os_tick high on consecutive clks) are legal and handled.
- Parity is not supported.

Decomposition:
- Shared package uart_pkg:
  - state encoding constants: IDLE, START, DATA, STOP, BREAK (3 bits);
  - default OVERSAMPLING and DATA_BITS constants, shared with the transmitter side.
- Sub-module rx_sync_vote: 2-flop synchronizer plus 3-sample majority register.
  - Inputs: clk, rst, rxd, sample enable.
  - Outputs: rxd_s and vote.
- The FSM and counters stay in uart_rx.

Test Plan:
- Frame 0x55 (OVERSAMPLING = 8, tick every 4 clks, clean 8N1) -> one data_valid pulse with data = 0x55; framing_err stays 0; busy falls after mid-stop.
- rxd low for 2 ticks only (glitch) -> false start; busy returns to 0 by tick M+1; no pulses.
- Frame 0xA3 with stop bit = 0 and line then held low 20 bit-times:
  - one framing_err pulse; no data_valid; data keeps its prior value;
  - state stays BREAK until rxd goes high; no extra frames are detected.
- Frame 0x00 with rxd forced high for 1 tick at os_cnt = M in bit 3 -> majority rejects the glitch; data = 0x00.
- Reset asserted mid-frame at bit 4, then frame 0x3C:
  - during reset, all outputs are 0;
  - after reset, 0x3C is received with a single data_valid pulse.
- Back-to-back frames 0x00 then 0xFF with zero idle gap -> two data_valid pulses, spaced 10 bit-times apart, with data 0x00 then 0xFF.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: receiver FSM state encoding and frame defaults shared by both sides of the UART.
package uart_pkg;
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;
    localparam int OVERSAMPLING_DEF = 8;
    localparam int DATA_BITS_DEF = 8;
endpackage

// File: rtl/rx_sync_vote.sv
// rx_sync_vote: two-flop synchronizer for the raw rx line plus a three-sample majority vote.
module rx_sync_vote (
    input  logic clk,
    input  logic rst,
    input  logic rxd_i,
    input  logic sample_i,
    output logic rxd_s_o,
    output logic vote_o
);
    logic [1:0] sync_q;
    logic [1:0] samp_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= 2'b11;
            samp_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], rxd_i};
            if (sample_i) samp_q <= {samp_q[0], rxd_s_o};
        end
    end
    assign rxd_s_o = sync_q[1];
    // The third sample is the live line, so the vote is ready on the decision tick itself
    assign vote_o = (samp_q[1] & samp_q[0]) | (samp_q[1] & rxd_s_o) | (samp_q[0] & rxd_s_o);
endmodule

// File: rtl/uart_rx.sv
// uart_rx: oversampled 8N1-style receiver with mid-bit majority voting,
// a one-cycle valid pulse per good frame and a framing-error pulse on a bad stop bit.
module uart_rx import uart_pkg::*; #(
    parameter int OVERSAMPLING = OVERSAMPLING_DEF,
    parameter int DATA_BITS = DATA_BITS_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 os_tick,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] data,
    output logic                 data_valid,
    output logic                 framing_err,
    output logic                 busy
);
    localparam int CW = $clog2(OVERSAMPLING);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] LO = CW'(OVERSAMPLING / 2 - 1);
    localparam logic [CW-1:0] HI = CW'(OVERSAMPLING / 2 + 1);
    localparam logic [CW-1:0] LAST = CW'(OVERSAMPLING - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

    state_t               state_q;
    logic [CW-1:0]        os_cnt_q;
    logic [BW-1:0]        bit_cnt_q;
    logic [DATA_BITS-1:0] shift_q;
    logic [DATA_BITS-1:0] data_q;
    logic                 valid_q;
    logic                 ferr_q;
    logic                 rxd_s;
    logic                 vote;
    logic                 sample;
    logic                 decide;

    assign sample = os_tick && (state_q inside {START, DATA, STOP}) && os_cnt_q >= LO && os_cnt_q <= HI;
    assign decide = os_tick && os_cnt_q == HI;

    rx_sync_vote u_sync_vote (
        .clk      (clk),
        .rst      (rst),
        .rxd_i    (rxd),
        .sample_i (sample),
        .rxd_s_o  (rxd_s),
        .vote_o   (vote)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            os_cnt_q  <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            if (os_tick) begin
                os_cnt_q <= os_cnt_q + 1'b1;
                case (state_q)
                    IDLE: begin
                        os_cnt_q <= '0;
                        if (!rxd_s) state_q <= START;
                    end
                    START: begin
                        if (decide && vote) begin
                            state_q  <= IDLE;
                            os_cnt_q <= '0;
                        end else if (os_cnt_q == LAST) begin
                            state_q   <= DATA;
                            bit_cnt_q <= '0;
                        end
                    end
                    DATA: begin
                        if (decide) shift_q <= {vote, shift_q[DATA_BITS-1:1]};
                        if (os_cnt_q == LAST) begin
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                            if (bit_cnt_q == LAST_BIT) begin
                                state_q   <= STOP;
                                bit_cnt_q <= '0;
                            end
                        end
                    end
                    STOP: begin
                        // Leaving at mid-stop-bit leaves half a bit to catch the next start edge
                        if (decide) begin
                            os_cnt_q <= '0;
                            state_q  <= vote ? IDLE : BREAK;
                            valid_q  <= vote;
                            ferr_q   <= !vote;
                            if (vote) data_q <= shift_q;
                        end
                    end
                    BREAK: begin
                        os_cnt_q <= '0;
                        if (rxd_s) state_q <= IDLE;
                    end
                    default: begin
                        state_q  <= IDLE;
                        os_cnt_q <= '0;
                    end
                endcase
            end
        end
    end

    assign data        = data_q;
    assign data_valid  = valid_q;
    assign framing_err = ferr_q;
    assign busy        = state_q != IDLE;
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed frames against uart_rx with oversample tick every 4 clks (32 clks per bit).
module tb_uart_rx;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rxd = 1'b1;
    logic [1:0] div = 2'd0;
    logic       os_tick;
    logic [7:0] data;
    logic       data_valid;
    logic       framing_err;
    logic       busy;
    int         checks = 0;
    int         failures = 0;
    int         cyc = 0;
    int         vcnt = 0;
    int         fcnt = 0;
    int         vtime = 0;
    int         vtime_prev = 0;
    logic [7:0] vdata = 8'h00;
    logic [7:0] vdata_prev = 8'h00;

    uart_rx #(.OVERSAMPLING(8), .DATA_BITS(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .os_tick     (os_tick),
        .rxd         (rxd),
        .data        (data),
        .data_valid  (data_valid),
        .framing_err (framing_err),
        .busy        (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) div <= div + 2'd1;
    assign os_tick = (div == 2'd3);

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (data_valid) begin
            vcnt       <= vcnt + 1;
            vtime_prev <= vtime;
            vtime      <= cyc;
            vdata_prev <= vdata;
            vdata      <= data;
        end
        if (framing_err) fcnt <= fcnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic align();
        while (div != 2'd0) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        rxd = b;
        wait_clks(32);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        align();
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(stop);
    endtask

    initial begin
        wait_clks(3);
        check("rst_data", data, 8'h00);
        check("rst_valid", data_valid, 1'b0);
        check("rst_ferr", framing_err, 1'b0);
        check("rst_busy", busy, 1'b0);
        rst = 1'b0;
        wait_clks(40);

        align();
        send_bit(1'b0);
        check("f55_busy_mid", busy, 1'b1);
        for (int i = 0; i < 8; i++) send_bit(i[0] ? 1'b0 : 1'b1);
        send_bit(1'b1);
        check("f55_vcnt", vcnt, 1);
        check("f55_data", data, 8'h55);
        check("f55_fcnt", fcnt, 0);
        check("f55_busy_end", busy, 1'b0);
        wait_clks(32);

        align();
        rxd = 1'b0;
        wait_clks(8);
        check("glitch_busy_start", busy, 1'b1);
        rxd = 1'b1;
        wait_clks(32);
        check("glitch_busy_end", busy, 1'b0);
        check("glitch_vcnt", vcnt, 1);
        check("glitch_fcnt", fcnt, 0);

        send_frame(8'hA3, 1'b0);
        wait_clks(32 * 20);
        check("brk_fcnt", fcnt, 1);
        check("brk_vcnt", vcnt, 1);
        check("brk_data", data, 8'h55);
        check("brk_busy_held", busy, 1'b1);
        rxd = 1'b1;
        wait_clks(64);
        check("brk_busy_release", busy, 1'b0);
        check("brk_fcnt_after", fcnt, 1);
        check("brk_vcnt_after", vcnt, 1);

        align();
        rxd = 1'b0;
        wait_clks(144);
        rxd = 1'b1;
        wait_clks(4);
        rxd = 1'b0;
        wait_clks(140);
        rxd = 1'b1;
        wait_clks(32);
        check("vote_vcnt", vcnt, 2);
        check("vote_data", data, 8'h00);
        check("vote_fcnt", fcnt, 1);
        wait_clks(32);

        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        check("b2b_vcnt", vcnt, 4);
        check("b2b_first", vdata_prev, 8'h00);
        check("b2b_second", vdata, 8'hFF);
        check("b2b_data", data, 8'hFF);
        check("b2b_spacing", vtime - vtime_prev, 320);
        check("b2b_fcnt", fcnt, 1);
        wait_clks(32);

        align();
        send_bit(1'b0);
        repeat (4) send_bit(1'b1);
        wait_clks(10);
        check("pre_rst_busy", busy, 1'b1);
        rst = 1'b1;
        wait_clks(2);
        check("mid_rst_data", data, 8'h00);
        check("mid_rst_valid", data_valid, 1'b0);
        check("mid_rst_ferr", framing_err, 1'b0);
        check("mid_rst_busy", busy, 1'b0);
        rxd = 1'b1;
        wait_clks(2);
        rst = 1'b0;
        wait_clks(40);
        check("post_rst_vcnt", vcnt, 4);
        send_frame(8'h3C, 1'b1);
        wait_clks(40);
        check("f3c_vcnt", vcnt, 5);
        check("f3c_data", data, 8'h3C);
        check("f3c_fcnt", fcnt, 1);
        check("f3c_busy", busy, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
